// File: rtl/or16_frame_reducer_if.sv
// Handshake bundle between a word producer, the OR reducer and its result consumer.
interface or16_frame_reducer_if;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [15:0] out_data;
    logic [4:0]  out_count;
    logic        out_forced;
    logic        out_full;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_count, out_forced, out_full, out_valid
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_count, out_forced, out_full, out_valid
    );
endinterface

// File: rtl/or16_frame_reducer.sv
// ORs the words of a frame together and presents the result, word count and close reason.
//   state   | meaning
//   S_IDLE  | no words in frame
//   S_ACCUM | frame open, accumulating
//   S_DONE  | result pending, held until out_ready
module or16_frame_reducer #(
    parameter int MAX_WORDS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    or16_frame_reducer_if.slave   bus
);

    localparam logic [4:0] LP_MAX = 5'(MAX_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t      r_state;
    logic [15:0] r_acc;
    logic [4:0]  r_count;
    logic        r_forced;
    logic        r_out_valid;
    logic        r_in_ready;

    logic        w_accept;
    logic [4:0]  w_count_inc;

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_count_inc = r_count + 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_acc       <= 16'h0000;
            r_count     <= 5'd0;
            r_forced    <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_acc   <= bus.in_data;
                        r_count <= 5'd1;
                        if (bus.in_last || (MAX_WORDS == 1)) begin
                            r_state     <= S_DONE;
                            r_forced    <= !bus.in_last;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= r_acc | bus.in_data;
                        r_count <= w_count_inc;
                        // in_last on the limit word wins: the frame ended normally
                        if (bus.in_last || (w_count_inc == LP_MAX)) begin
                            r_state     <= S_DONE;
                            r_forced    <= !bus.in_last;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_acc       <= 16'h0000;
                        r_count     <= 5'd0;
                        r_forced    <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_acc       <= 16'h0000;
                    r_count     <= 5'd0;
                    r_forced    <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_acc;
    assign bus.out_count  = r_count;
    assign bus.out_forced = r_forced;
    assign bus.out_full   = (r_acc == 16'hFFFF);

endmodule

// File: tb/tb_or16_frame_reducer.sv
// Scoreboard bench for the OR frame reducer: a word-level model predicts each result.
module tb_or16_frame_reducer;

    localparam int MAXW = 16;

    logic clk;
    logic reset;

    or16_frame_reducer_if bus_if ();

    or16_frame_reducer #(.MAX_WORDS(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // expected result: {data[15:0], count[4:0], forced, full}
    logic [22:0] exp_q[$];
    logic [15:0] mdl_acc;
    int          mdl_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on the edge where a word is accepted.
    task automatic model_word(input logic [15:0] d, input logic last);
        mdl_acc = (mdl_cnt == 0) ? d : (mdl_acc | d);
        mdl_cnt++;
        if (last || mdl_cnt == MAXW) begin
            exp_q.push_back({mdl_acc, 5'(mdl_cnt), !last, (mdl_acc == 16'hFFFF)});
            mdl_acc = 16'h0000;
            mdl_cnt = 0;
        end
    endtask

    // Entered and left at posedge+1.
    task automatic send_word(input logic [15:0] d, input logic last);
        int n;
        n = 0;
        bus_if.in_data  = d;
        bus_if.in_last  = last;
        bus_if.in_valid = 1'b1;
        while (!bus_if.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            check_val("accept_timeout", 32'(n), 32'd0);
        end else begin
            @(posedge clk);
            model_word(d, last);
            #1;
        end
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_result", {16'h0, bus_if.out_data}, 32'hDEAD_0000);
            end else begin
                logic [22:0] e;
                e = exp_q.pop_front();
                check_val("sb_data",   32'(bus_if.out_data),   32'(e[22:7]));
                check_val("sb_count",  32'(bus_if.out_count),  32'(e[6:2]));
                check_val("sb_forced", 32'(bus_if.out_forced), 32'(e[1]));
                check_val("sb_full",   32'(bus_if.out_full),   32'(e[0]));
            end
        end
    end

    initial begin
        int n;
        mdl_acc          = 16'h0000;
        mdl_cnt          = 0;
        reset            = 1'b1;
        bus_if.in_data   = 16'h0000;
        bus_if.in_valid  = 1'b0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b1;

        #2;
        check_val("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check_val("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
        check_val("rst_out_data",  32'(bus_if.out_data),  32'd0);
        check_val("rst_out_count", 32'(bus_if.out_count), 32'd0);
        check_val("rst_forced",    32'(bus_if.out_forced), 32'd0);
        idle_cycles(2);
        reset = 1'b0;
        idle_cycles(1);

        // single word, result visible right after the accepting edge
        send_word(16'h1234, 1'b1);
        check_val("single_valid", 32'(bus_if.out_valid), 32'd1);
        check_val("single_data",  32'(bus_if.out_data),  32'h1234);
        check_val("single_ready", 32'(bus_if.in_ready),  32'd0);
        idle_cycles(1);

        send_word(16'hAAAA, 1'b0);
        send_word(16'h5555, 1'b1);
        check_val("full_flag", 32'(bus_if.out_full), 32'd1);
        idle_cycles(1);
        send_word(16'h3CC3, 1'b0);
        send_word(16'h0FF0, 1'b1);
        check_val("notfull_data", 32'(bus_if.out_data), 32'h3FF3);
        idle_cycles(1);

        // forced close at MAX_WORDS, all-ones not involved; 17th word must stall
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < MAXW; i++) send_word(16'h0001, 1'b0);
        check_val("forced_valid", 32'(bus_if.out_valid),  32'd1);
        check_val("forced_flag",  32'(bus_if.out_forced), 32'd1);
        check_val("forced_count", 32'(bus_if.out_count),  32'd16);
        bus_if.in_data  = 16'h8000;
        bus_if.in_valid = 1'b1;
        idle_cycles(2);
        check_val("w17_stalled", 32'(bus_if.in_ready), 32'd0);
        check_val("w17_no_merge", 32'(bus_if.out_data), 32'h0001);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        idle_cycles(2);

        // limit word with in_last is a normal close
        for (int i = 0; i < MAXW - 1; i++) send_word(16'h0100, 1'b0);
        send_word(16'h0200, 1'b1);
        check_val("limit_last_forced", 32'(bus_if.out_forced), 32'd0);
        idle_cycles(1);

        // backpressure with garbage presented while stalled
        bus_if.out_ready = 1'b0;
        send_word(16'h1234, 1'b0);
        send_word(16'h9876, 1'b1);
        bus_if.in_data  = 16'hFFFF;
        bus_if.in_last  = 1'b1;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle_cycles(1);
            check_val("bp_data",     32'(bus_if.out_data),  32'h9A76);
            check_val("bp_count",    32'(bus_if.out_count), 32'd2);
            check_val("bp_in_ready", 32'(bus_if.in_ready),  32'd0);
            check_val("bp_valid",    32'(bus_if.out_valid), 32'd1);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b1;
        idle_cycles(1);
        check_val("bp_release_valid", 32'(bus_if.out_valid), 32'd0);
        check_val("bp_release_ready", 32'(bus_if.in_ready),  32'd1);
        send_word(16'h0042, 1'b1);
        idle_cycles(1);

        // async reset mid-frame discards the partial frame
        send_word(16'h00F0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_val("arst_count", 32'(bus_if.out_count), 32'd0);
        check_val("arst_data",  32'(bus_if.out_data),  32'd0);
        check_val("arst_ready", 32'(bus_if.in_ready),  32'd1);
        reset   = 1'b0;
        mdl_acc = 16'h0000;
        mdl_cnt = 0;
        @(posedge clk); #1;
        send_word(16'h0F00, 1'b1);
        check_val("post_rst_data",  32'(bus_if.out_data),  32'h0F00);
        check_val("post_rst_count", 32'(bus_if.out_count), 32'd1);
        idle_cycles(1);

        // in_valid toggling, with a stray in_last while in_valid is low
        send_word(16'h0001, 1'b0);
        bus_if.in_last = 1'b1;
        idle_cycles(1);
        bus_if.in_last = 1'b0;
        send_word(16'h0002, 1'b0);
        idle_cycles(1);
        send_word(16'h0004, 1'b1);
        check_val("toggle_data",  32'(bus_if.out_data),  32'h0007);
        check_val("toggle_count", 32'(bus_if.out_count), 32'd3);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/or16_frame_reducer.md
OR16_FRAME_REDUCER -- requirements
Module: or16_frame_reducer

Interface
REQ-001 SHALL have parameter: MAX_WORDS, default 16, maximum words per frame before forced close (legal range 1..31).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_data  input  16  word to OR into the current frame.
REQ-005 SHALL have port: in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port: in_last  input  1  qualifies in_data as the final word of the frame.
REQ-007 SHALL have port: in_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port: out_data  output  16  bitwise OR of all words in the completed frame.
REQ-009 SHALL have port: out_count  output  5  number of words in the completed frame (1..MAX_WORDS).
REQ-010 SHALL have port: out_forced  output  1  frame closed by MAX_WORDS limit, not by in_last.
REQ-011 SHALL have port: out_full  output  1  out_data == 16'hFFFF.
REQ-012 SHALL have port: out_valid  output  1  result fields are valid and held.
REQ-013 SHALL have port: out_ready  input  1  consumer accepts the result this cycle.

Function
REQ-014 SHALL implement three states: IDLE (no words in frame), ACCUM (frame open), DONE (result pending).
REQ-015 SHALL define a word as accepted when in_valid && in_ready at a rising edge; result as accepted when out_valid && out_ready.
REQ-016 SHALL drive in_ready = 1 in IDLE and ACCUM, 0 in DONE; in_ready SHALL NOT depend combinationally on out_ready.
REQ-017 SHALL drive out_valid = 1 only in DONE; out_data, out_count, out_forced, out_full SHALL be stable throughout DONE.
REQ-018 IDLE + accepted word: acc <= in_data, count <= 1; next state DONE if in_last or MAX_WORDS == 1, else ACCUM.
REQ-019 ACCUM + accepted word: acc <= acc | in_data, count <= count + 1; next state DONE if in_last or count + 1 == MAX_WORDS, else ACCUM.
REQ-020 SHALL set out_forced = 1 when entering DONE via the MAX_WORDS limit with in_last = 0; in_last on the limit word SHALL give out_forced = 0.
REQ-021 IDLE/ACCUM with no accepted word: state, acc, count unchanged (in_valid without in_ready has no effect).
REQ-022 DONE + out_ready: next state IDLE, acc <= 0, count <= 0, out_forced <= 0; DONE without out_ready: hold all fields indefinitely.
REQ-023 Latency: out_valid SHALL assert on the rising edge that accepts the closing word (visible the cycle after it is presented); minimum frame-to-frame spacing is one idle-accept cycle after result acceptance.
REQ-024 in_data/in_last while in_ready = 0 SHALL be ignored; no word may be dropped or merged across frames.
REQ-025 out_data SHALL equal acc; out_count SHALL equal count; count SHALL never exceed MAX_WORDS and never wrap.
REQ-026 out_full SHALL be computed from acc and reported only as part of the held result; an all-ones accumulator SHALL NOT close the frame early.
REQ-027 in_last asserted with in_valid = 0 SHALL have no effect.

Reset
REQ-028 reset = 1 SHALL immediately, without waiting for clk, force state IDLE, acc = 0, count = 0, out_forced = 0, out_valid = 0, in_ready = 1.
REQ-029 reset asserted mid-frame (ACCUM) or with a result pending (DONE) SHALL discard the partial frame/result; no result for it SHALL ever be presented.
REQ-030 First word accepted SHALL be the first with in_valid = 1 at a rising edge after reset deasserts.

Verification
REQ-031 Single word 16'h1234 with in_last, out_ready = 1 -> next cycle out_valid = 1, out_data = 16'h1234, out_count = 1, out_forced = 0, out_full = 0.
REQ-032 Words 16'hAAAA, 16'h5555 (last) -> out_data = 16'hFFFF, out_count = 2, out_full = 1; with 16'h3CC3, 16'h0FF0 (last) -> out_data = 16'h3FF3, out_full = 0.
REQ-033 16 words of 16'h0001 with in_last never asserted, MAX_WORDS = 16 -> out_valid after 16th accept, out_data = 16'h0001, out_count = 16, out_forced = 1; 17th word stalled (in_ready = 0).
REQ-034 Backpressure: out_ready = 0 for 5 cycles after result 16'h9A76 (frame 16'h1234, 16'h9876 last) -> result held unchanged, in_ready = 0; out_ready = 1 -> IDLE next cycle, next frame accepted normally.
REQ-035 reset pulsed between clock edges during ACCUM after 16'h00F0 -> outputs cleared asynchronously; following frame 16'h0F00 (last) -> out_data = 16'h0F00, out_count = 1.
REQ-036 in_valid toggling 1/0 within a 3-word frame 16'h0001, 16'h0002, 16'h0004 (last) -> out_data = 16'h0007, out_count = 3, no extra or lost words.
